// File: rtl/example.sv
// example: unsigned 2-bit x 2-bit multiplier leaf, result = a*b (4 bits, max 9).
// Latency: 0 cycles by default; 1 cycle when EXAMPLE_OUTPUT_REG_EN is defined.
// Backpressure: none (no handshake); the output register loads on every edge.
module example (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] result
);

  // Operands regrouped as one packed record: a in [3:2], b in [1:0].
  logic [3:0] opnd_rec;
  logic [3:0] opnd_a_ext;
  logic [3:0] opnd_b_ext;
  logic [3:0] product;

  assign opnd_rec = {a, b};

  // Zero-extend both fields to the result width so the multiply is
  // full-width; 3*3 = 9 fits, so no truncation or saturation is needed.
  assign opnd_a_ext = {2'b00, opnd_rec[3:2]};
  assign opnd_b_ext = {2'b00, opnd_rec[1:0]};
  assign product    = opnd_a_ext * opnd_b_ext;

`ifdef EXAMPLE_OUTPUT_REG_EN
  logic [3:0] result_d;
  logic [3:0] result_q;

  assign result_d = product;

  // Output register: loads every edge, clears asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= 4'b0000;
    end else begin
      result_q <= result_d;
    end
  end

  assign result = result_q;
`else
  // Combinational build: clock and reset stay on the boundary but are unused.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  assign result = product;
`endif

endmodule

// File: tb/tb_example.sv
// Directed bench for example: product sweep, zero operand, commutativity,
// reset and latency behaviour, for whichever build the macro selects.
module tb_example;

  logic       clk;
  logic       rst_n;
  logic [1:0] a;
  logic [1:0] b;
  logic [3:0] result;

  int checks;
  int failures;

  logic [3:0] exp_tab [16];
  logic [3:0] rec;

  example dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive operands after a falling edge and let the result settle
  // (one rising edge in the registered build, a short delay otherwise).
  task automatic apply(input logic [1:0] av, input logic [1:0] bv);
    @(negedge clk);
    a = av;
    b = bv;
`ifdef EXAMPLE_OUTPUT_REG_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    // Hand-computed products indexed by {a,b}.
    exp_tab = '{4'd0, 4'd0, 4'd0, 4'd0,
                4'd0, 4'd1, 4'd2, 4'd3,
                4'd0, 4'd2, 4'd4, 4'd6,
                4'd0, 4'd3, 4'd6, 4'd9};

    // Reset held with a=3, b=3 and clock running.
    rst_n = 1'b0;
    a     = 2'd3;
    b     = 2'd3;
    repeat (3) @(posedge clk);
    #1;
`ifdef EXAMPLE_OUTPUT_REG_EN
    check("reset_hold", result, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_release_pre_edge", result, 4'b0000);
    @(posedge clk);
    #1;
    check("reset_release_first_edge", result, 4'b1001);
`else
    check("reset_no_effect", result, 4'b1001);
    rst_n = 1'b1;
`endif

    // Exhaustive sweep of the packed record {a,b}.
    for (int i = 0; i < 16; i++) begin
      rec = i[3:0];
      apply(rec[3:2], rec[1:0]);
      check($sformatf("sweep_%0d", i), result, exp_tab[i]);
    end

    // Zero operand on either side.
    apply(2'b11, 2'b00);
    check("zero_b", result, 4'b0000);
    apply(2'b00, 2'b10);
    check("zero_a", result, 4'b0000);

    // Commutativity.
    apply(2'd2, 2'd3);
    check("comm_2x3", result, 4'b0110);
    apply(2'd3, 2'd2);
    check("comm_3x2", result, 4'b0110);

    // Latency: change inputs just after a rising edge.
    apply(2'd3, 2'd3);
    check("latency_setup", result, 4'b1001);
    @(posedge clk);
    #1;
    a = 2'd1;
    b = 2'd2;
    #1;
`ifdef EXAMPLE_OUTPUT_REG_EN
    check("latency_hold_old", result, 4'b1001);
    @(posedge clk);
    #1;
    check("latency_next_edge", result, 4'b0010);
`else
    check("latency_immediate", result, 4'b0010);
`endif

    // Mid-stream reset pulse between edges.
    apply(2'd3, 2'd3);
    check("midreset_setup", result, 4'b1001);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
`ifdef EXAMPLE_OUTPUT_REG_EN
    check("midreset_async_clear", result, 4'b0000);
    #1;
    rst_n = 1'b1;
    #1;
    check("midreset_wait_edge", result, 4'b0000);
    @(posedge clk);
    #1;
    check("midreset_recover", result, 4'b1001);
`else
    check("midreset_no_effect", result, 4'b1001);
    rst_n = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
